keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad and hands a clean key code to the keypad decoder.
- Drives one column at a time and samples the four row lines through a synchronizer.
- Debounces press and release.
- Presents keypad_val = {row[3:0], col[3:0]}: one-hot row in the upper nibble, one-hot column in the lower nibble, the exact encoding the decoder consumes.
- Emits a single-cycle key_valid per debounced press.
- Sits between the keypad pins and keypad_decoder, upstream of the display logic.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven during scanning; must be >= 4.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a press or a release; must be >= 2.
- REPEAT_CYCLES, 250000: auto-repeat period; used only when KEYPAD_REPEAT_EN is defined.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- row  in  4  raw keypad row lines, asynchronous, active-high (pulled down off-board)
- col  out  4  one-hot column drive, active-high
- keypad_val  out  8  {row, col} of the last accepted key; feeds keypad_decoder
- key_valid  out  1  one-cycle pulse per accepted press
- key_held  out  1  high while the accepted key is held (debounced)

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low: it is sampled on the clk rising edge while reset==0.
- Reset values: col=4'b1000, keypad_val=8'h00, key_valid=0, key_held=0. FSM is in SCAN, all counters are 0, synchronizer flops are 0.
- Synchronization: row passes through a 2-flop synchronizer to produce row_s, adding 2 cycles of latency. All decisions use row_s.
- Column rotation order: 1000 -> 0100 -> 0010 -> 0001 -> 1000.
- Scan counter: sc counts 0..SCAN_DIV-1 and wraps. It resets to 0 on every column change.
- SCAN state:
  - row_s is sampled only when sc >= 3 (settling window).
  - If row_s is exactly one-hot: latch cand={row_s,col}, clear the debounce counter dc, go to DEBOUNCE.
  - If row_s has zero bits or multiple bits set: stay in SCAN. At sc==SCAN_DIV-1, rotate col.
- DEBOUNCE state: col is held.
  - Each cycle {row_s,col}==cand increments dc.
  - When dc reaches DEBOUNCE_CYCLES-1: go to PRESSED, load keypad_val<=cand, and pulse key_valid high for exactly the next cycle.
  - Any mismatch: go to SCAN with sc=0 and col unchanged.
- PRESSED state:
  - key_held=1 and col is held.
  - Only cand's row bit is watched; other keys are ignored.
  - When that row bit is 0: clear dc and go to RELEASE.
- RELEASE state:
  - Row bit 0 for DEBOUNCE_CYCLES consecutive cycles: key_held=0, rotate col, sc=0, go to SCAN.
  - Row bit returns to 1: go back to PRESSED with no new key_valid.
- keypad_val holds its value until the next accepted press.
- key_valid and key_held are registered outputs.
- Reset asserted in any state: all outputs return to their reset values on that edge, and no key_valid is emitted.
- Counter widths are $clog2 of the parameter value. No overflow is possible, because each counter is cleared on every transition.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined: in PRESSED, a repeat counter counts from entry. key_valid pulses again every REPEAT_CYCLES cycles while the key remains held. The counter clears on entering RELEASE, and a return from RELEASE to PRESSED restarts it.
- Undefined: exactly one key_valid per press. REPEAT_CYCLES is ignored and no repeat logic is synthesized.

Decomposition:
- Package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, PRESSED, RELEASE), 2 bits;
  - localparam COL_INIT=4'b1000;
  - localparam NO_KEY=8'h00.
- Sub-module row_sync: a parameterized-width 2-flop synchronizer with the same reset convention, instantiated at width 4 for row.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
1. Reset: hold reset=0 for 3 cycles -> col=1000, keypad_val=00, key_valid=0, key_held=0; col then rotates every 4 cycles.
2. Clean press and hold: when col==0100, drive row=0001 and hold it for 100 cycles -> exactly one key_valid pulse within 2+1+8 cycles, keypad_val=8'h14 (decoder output 4'h2), key_held=1, col frozen at 0100.
3. Press bounce: row=0001 during col==0100 for 5 cycles, then 0 -> no key_valid, keypad_val unchanged, scanning resumes from 0100.
4. Release bounce, then release:
   - In PRESSED, drop row for 4 cycles and restore it -> no new key_valid, key_held stays 1.
   - Then drop row for 10 cycles -> key_held=0 and col advances to 0010.
5. Multi-key and reset:
   - row=0011 during any column -> no key_valid.
   - reset=0 mid-DEBOUNCE -> no key_valid, col=1000 on the next cycle.
6. KEYPAD_REPEAT_EN defined with REPEAT_CYCLES=20: hold a key for 70 cycles past acceptance -> 4 key_valid pulses total, spaced 20 cycles apart.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } kstate_t;

   localparam logic [3:0] COL_INIT = 4'b1000;
   localparam logic [7:0] NO_KEY   = 8'h00;

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

   // Column walk is 1000 -> 0100 -> 0010 -> 0001 -> 1000.
   function automatic logic [3:0] rotate_col(input logic [3:0] c);
      return {c[0], c[3:1]};
   endfunction

endpackage

// File: rtl/row_sync.sv
// Parameterized-width two-flop synchronizer with synchronous active-low reset.
module row_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (!reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with press/release debounce; presents {row,col} of the accepted key.
// Optional auto-repeat of key_valid while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int REPEAT_CYCLES   = 250000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [7:0] keypad_val,
   output logic       key_valid,
   output logic       key_held
);

   import keypad_pkg::*;

   localparam int SCW = $clog2(SCAN_DIV);
   localparam int DCW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [SCW-1:0] SC_LAST   = SCW'(SCAN_DIV - 1);
   localparam logic [SCW-1:0] SC_SETTLE = SCW'(3);
   localparam logic [DCW-1:0] DC_LAST   = DCW'(DEBOUNCE_CYCLES - 1);

   generate
      if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
         $error("keypad_scanner: illegal parameter value");
      end
   endgenerate

   kstate_t        state, state_nxt;
   logic [SCW-1:0] sc, sc_nxt;
   logic [DCW-1:0] dc, dc_nxt;
   logic [7:0]     cand, cand_nxt;
   logic [3:0]     col_nxt;
   logic [7:0]     val_nxt;
   logic           valid_nxt, held_nxt;
   logic [3:0]     row_s;
   logic           match, watch_hit;

`ifdef KEYPAD_REPEAT_EN
   localparam int RCW = $clog2(REPEAT_CYCLES);
   localparam logic [RCW-1:0] RC_LAST = RCW'(REPEAT_CYCLES - 1);
   logic [RCW-1:0] rc, rc_nxt;
`endif

   row_sync #(.WIDTH(4)) u_row_sync (
      .clk   (clk),
      .reset (reset),
      .d     (row),
      .q     (row_s)
   );

   assign match     = ({row_s, col} == cand);
   assign watch_hit = |(cand[7:4] & row_s);

   always_ff @(posedge clk) begin
      if (!reset) state <= SCAN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SCAN:     if (sc >= SC_SETTLE && is_onehot(row_s)) state_nxt = DEBOUNCE;
         DEBOUNCE: if (!match)              state_nxt = SCAN;
                   else if (dc == DC_LAST)  state_nxt = PRESSED;
         PRESSED:  if (!watch_hit)          state_nxt = RELEASE;
         RELEASE:  if (watch_hit)           state_nxt = PRESSED;
                   else if (dc == DC_LAST)  state_nxt = SCAN;
         default:  state_nxt = SCAN;
      endcase
   end

   // Next values for the counters and registered outputs, keyed off the transition taken.
   always_comb begin
      sc_nxt    = sc;
      dc_nxt    = dc;
      cand_nxt  = cand;
      col_nxt   = col;
      val_nxt   = keypad_val;
      valid_nxt = 1'b0;
      held_nxt  = (state_nxt == PRESSED) || (state_nxt == RELEASE);
`ifdef KEYPAD_REPEAT_EN
      rc_nxt    = rc;
`endif
      case (state)
         SCAN: begin
            if (state_nxt == DEBOUNCE) begin
               cand_nxt = {row_s, col};
               dc_nxt   = '0;
               sc_nxt   = '0;
            end else if (sc == SC_LAST) begin
               sc_nxt  = '0;
               col_nxt = rotate_col(col);
            end else begin
               sc_nxt = sc + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (state_nxt == SCAN) begin
               sc_nxt = '0;
            end else if (state_nxt == PRESSED) begin
               val_nxt   = cand;
               valid_nxt = 1'b1;
`ifdef KEYPAD_REPEAT_EN
               rc_nxt    = '0;
`endif
            end else begin
               dc_nxt = dc + 1'b1;
            end
         end
         PRESSED: begin
            if (state_nxt == RELEASE) begin
               dc_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
               rc_nxt = '0;
            end else if (rc == RC_LAST) begin
               valid_nxt = 1'b1;
               rc_nxt    = '0;
            end else begin
               rc_nxt = rc + 1'b1;
`endif
            end
         end
         RELEASE: begin
            if (state_nxt == SCAN) begin
               col_nxt = rotate_col(col);
               sc_nxt  = '0;
            end else if (state_nxt == PRESSED) begin
`ifdef KEYPAD_REPEAT_EN
               rc_nxt = '0;
`endif
            end else begin
               dc_nxt = dc + 1'b1;
            end
         end
         default: begin
            sc_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sc         <= '0;
         dc         <= '0;
         cand       <= NO_KEY;
         col        <= COL_INIT;
         keypad_val <= NO_KEY;
         key_valid  <= 1'b0;
         key_held   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rc         <= '0;
`endif
      end else begin
         sc         <= sc_nxt;
         dc         <= dc_nxt;
         cand       <= cand_nxt;
         col        <= col_nxt;
         keypad_val <= val_nxt;
         key_valid  <= valid_nxt;
         key_held   <= held_nxt;
`ifdef KEYPAD_REPEAT_EN
         rc         <= rc_nxt;
`endif
      end
   end

endmodule
